// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the immediate format tag used by the encoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_SH   = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_LI   = 3'd6,
    FMT_RSVD = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADDI = 3'b000;

  // True when the value is a sign-extended 12-bit quantity.
  function automatic logic fits12(input logic [31:0] v);
    return (&v[31:11]) | ~(|v[31:11]);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packer with immediate range checks.
// Range checks exist only when IMM_ENCODER_RANGE_CHECK_EN is defined.
module imm_pack
  import riscv_pkg::*;
(
  input  imm_fmt_e    fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic [19:0] li_hi;

  // Upper part of LI rounds up when the low 12 bits will sign-extend negative.
  assign li_hi = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    inst = '0;
    case (fmt)
      FMT_I:  inst = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_SH: inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:  inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:  inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:  inst = {imm[31:12], rd, opcode};
      FMT_J:  inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_LI: begin
        if (fits12(imm)) inst = {imm[11:0], 5'd0, F3_ADDI, rd, OP_IMM};
        else             inst = {li_hi, rd, OP_LUI};
      end
      default: inst = '0;
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: err = !fits12(imm);
      FMT_SH:       err = |imm[31:5];
      FMT_B:        err = !((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
      FMT_U:        err = |imm[11:0];
      FMT_J:        err = !((&imm[31:20]) | ~(|imm[31:20])) | imm[0];
      FMT_LI:       err = 1'b0;
      default:      err = 1'b1;
    endcase
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Streaming RV32I instruction encoder with LI -> LUI+ADDI expansion.
// Optional range checking via IMM_ENCODER_RANGE_CHECK_EN (see imm_pack).
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic            out_last,
  output logic            out_err
);

  typedef enum logic {IDLE, LI_LO} state_e;

  state_e      state_reg, state_next;
  logic        valid_reg, valid_next;
  logic [31:0] inst_reg, inst_next;
  logic        last_reg, last_next;
  logic        err_reg, err_next;
  logic [4:0]  lo_rd_reg, lo_rd_next;
  logic [11:0] lo_imm_reg, lo_imm_next;

  imm_fmt_e    fmt;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic        accept;
  logic        two_beat;

  assign fmt = imm_fmt_e'(in_fmt);

  imm_pack u_pack (
    .fmt    (fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  assign in_ready = (state_reg == IDLE) && (!valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign two_beat = (fmt == FMT_LI) && !fits12(in_imm) && (|in_imm[11:0]);

  always_comb begin
    state_next  = state_reg;
    valid_next  = valid_reg;
    inst_next   = inst_reg;
    last_next   = last_reg;
    err_next    = err_reg;
    lo_rd_next  = lo_rd_reg;
    lo_imm_next = lo_imm_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          valid_next = 1'b1;
          inst_next  = pack_inst;
          err_next   = pack_err;
          last_next  = !two_beat;
          if (two_beat) begin
            state_next  = LI_LO;
            lo_rd_next  = in_rd;
            lo_imm_next = in_imm[11:0];
          end
        end else if (out_ready) begin
          valid_next = 1'b0;
        end
      end
      LI_LO: begin
        // Beat 1 is always pending here; swap in ADDI rd,rd,lo once it leaves.
        if (out_ready) begin
          valid_next = 1'b1;
          inst_next  = {lo_imm_reg, lo_rd_reg, F3_ADDI, lo_rd_reg, OP_IMM};
          last_next  = 1'b1;
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      valid_reg  <= 1'b0;
      inst_reg   <= '0;
      last_reg   <= 1'b0;
      err_reg    <= 1'b0;
      lo_rd_reg  <= '0;
      lo_imm_reg <= '0;
    end else begin
      state_reg  <= state_next;
      valid_reg  <= valid_next;
      inst_reg   <= inst_next;
      last_reg   <= last_next;
      err_reg    <= err_next;
      lo_rd_reg  <= lo_rd_next;
      lo_imm_reg <= lo_imm_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_inst  = inst_reg;
  assign out_last  = last_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder; expected words are hand-computed.
module tb_imm_encoder;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_encoder #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for in_ready, and let it transfer.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    $display("send fmt=%0d rd=%0d imm=%h", fmt, rd, imm);
  endtask

  task automatic beat(input string tag, input logic [31:0] inst, input logic last, input logic err);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, inst);
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
    $display("beat %s inst=%h last=%0b err=%0b", tag, out_inst, out_last, out_err);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    send(3'd2, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
    beat("s_neg4", 32'hFE512E23, 1'b1, 1'b0);

    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF);
    beat("li_b1", 32'h123460B7, 1'b0, 1'b0);
    chk("li_in_ready_mid", {31'd0, in_ready}, 32'd0);
    beat("li_b2", 32'hFFF08093, 1'b1, 1'b0);

    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h0000_5000);
    beat("li_lui_only", 32'h000051B7, 1'b1, 1'b0);
    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h0000_0005);
    beat("li_addi", 32'h00500193, 1'b1, 1'b0);

    send(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'h0000_0003);
    beat("b_odd", 32'h00208163, 1'b1, RC);
    send(3'd0, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'h0000_0800);
    beat("i_2048", 32'h80008093, 1'b1, RC);
    send(3'd5, 7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFE);
    beat("j_neg2", 32'hFFFFF0EF, 1'b1, 1'b0);
    send(3'd4, 7'b0110111, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5000);
    beat("u_ok", 32'h12345137, 1'b1, 1'b0);
    send(3'd1, 7'b0010011, 3'b101, 7'b0100000, 5'd5, 5'd4, 5'd0, 32'h0000_0003);
    beat("sh_ok", 32'h40325293, 1'b1, 1'b0);
    send(3'd1, 7'b0010011, 3'b101, 7'b0100000, 5'd5, 5'd4, 5'd0, 32'h0000_0020);
    beat("sh_big", 32'h40025293, 1'b1, RC);
    send(3'd7, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd1, 5'd1, 32'h0000_0001);
    beat("rsvd", 32'h0000_0000, 1'b1, RC);

    // Backpressure on LI beat 1.
    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_inst", out_inst, 32'h123460B7);
      chk("bp_last", {31'd0, out_last}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      $display("backpressure cycle %0d inst=%h", i, out_inst);
    end
    out_ready = 1'b1;
    beat("bp_b2", 32'hFFF08093, 1'b1, 1'b0);

    // Reset while waiting for LI beat 2.
    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF);
    out_ready = 1'b0;
    @(negedge clk);
    chk("rli_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rli_valid", {31'd0, out_valid}, 32'd0);
    chk("rli_in_ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rli_no_stray", {31'd0, out_valid}, 32'd0);
    end
    $display("reset during LI_LO done");

    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h0000_0005);
    beat("post_rst", 32'h00500193, 1'b1, 1'b0);
    @(negedge clk);
    chk("idle_valid_drop", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
